// File: rtl/fast_ram_16k.sv
// 16K x 16 word RAM: one synchronous write port and a combinational read port.
// The RAM is built as four banks selected by the high address bits. An asynchronous reset clears every word.
module fast_ram_16k #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14,
   parameter int BANK_BITS  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [DATA_WIDTH-1:0] out,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  load
);

   localparam int OFF_BITS   = ADDR_WIDTH - BANK_BITS;
   localparam int NUM_BANKS  = 1 << BANK_BITS;
   localparam int BANK_DEPTH = 1 << OFF_BITS;

   logic [BANK_BITS-1:0]  bank;
   logic [OFF_BITS-1:0]   offset;
   logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];

   assign bank   = address[ADDR_WIDTH-1 -: BANK_BITS];
   assign offset = address[OFF_BITS-1:0];

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
      logic                  bank_we;

      // Only the bank named by the high address bits sees the write strobe.
      assign bank_we = load && (bank == BANK_BITS'(b));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
               mem[i] <= '0;
            end
         end else if (bank_we) begin
            mem[offset] <= in;
         end
      end

      assign bank_rd[b] = mem[offset];
   end

   // The read path is combinational. A write becomes visible right after its edge.
   always_comb begin
      out = '0;
      if (rst_n) begin
         out = bank_rd[bank];
      end
   end

endmodule

// File: tb/tb_fast_ram_16k.sv
// Self-checking bench for fast_ram_16k.
// A driver pushes expected read data from an array model into a queue, and a monitor process pops and compares it.
module tb_fast_ram_16k;

   logic        clk;
   logic        rst_n;
   logic [15:0] out;
   logic [15:0] in;
   logic [13:0] address;
   logic        load;

   fast_ram_16k dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .out     (out),
      .in      (in),
      .address (address),
      .load    (load)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: plain word array plus the list of addresses ever written
   logic [15:0] ref_mem [16384];
   logic [13:0] written_q [$];

   // scoreboard
   logic [15:0] exp_q [$];
   string       name_q [$];
   int          req_cnt = 0;
   int          done_cnt = 0;
   int          compared = 0;
   int          mismatched = 0;

   task automatic model_reset();
      for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0000;
   endtask

   // Read check at the present address. It waits 1 ns so the combinational read can settle.
   task automatic check(input string name);
      #1;
      exp_q.push_back(rst_n ? ref_mem[address] : 16'h0000);
      name_q.push_back(name);
      req_cnt++;
      wait (done_cnt == req_cnt);
   endtask

   // monitor
   initial begin
      forever begin
         logic [15:0] e;
         string       n;
         wait (req_cnt != done_cnt);
         e = exp_q.pop_front();
         n = name_q.pop_front();
         compared++;
         if (out !== e) begin
            mismatched++;
            $display("FAIL %s addr=%h got=%h exp=%h", n, address, out, e);
         end
         done_cnt++;
      end
   end

   // drivers
   task automatic read_at(input logic [13:0] a, input string name);
      address = a;
      check(name);
   endtask

   task automatic do_write(input logic [13:0] a, input logic [15:0] d, input logic ld, input string name);
      @(negedge clk);
      address = a;
      in      = d;
      load    = ld;
      @(posedge clk);
      if (ld && rst_n) begin
         ref_mem[a] = d;
         written_q.push_back(a);
      end
      #1;
      load = 1'b0;
      check(name);
   endtask

   initial begin
      logic [13:0] a;
      logic [15:0] d;
      rst_n   = 1'b0;
      in      = 16'h0000;
      address = 14'h0000;
      load    = 1'b0;
      model_reset();

      // 1: reset, then read
      #2;
      read_at(14'h1234, "in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      read_at(14'h0000, "rst_0000");
      read_at(14'h1800, "rst_1800");
      read_at(14'h3FFF, "rst_3fff");

      // 2: writes across the banks
      do_write(14'h0800, 16'h0001, 1'b1, "wr_0800");
      do_write(14'h1000, 16'h0003, 1'b1, "wr_1000");
      do_write(14'h1801, 16'h007F, 1'b1, "wr_1801");
      do_write(14'h2001, 16'h00FF, 1'b1, "wr_2001");
      @(negedge clk);
      read_at(14'h0800, "rd_0800");
      read_at(14'h1000, "rd_1000");
      read_at(14'h1801, "rd_1801");
      read_at(14'h2001, "rd_2001");

      // 3: load=0 leaves the memory unchanged
      do_write(14'h1800, 16'h0007, 1'b0, "noload_1800");
      do_write(14'h0001, 16'h000F, 1'b0, "noload_0001");
      do_write(14'h1001, 16'h003F, 1'b0, "noload_1001");

      // 4: a write does not disturb the adjacent word
      do_write(14'h0801, 16'h001F, 1'b1, "wr_0801");
      @(negedge clk);
      read_at(14'h0800, "adj_0800");
      read_at(14'h0801, "adj_0801");

      // 5: combinational read between edges, then read-during-write
      @(negedge clk);
      read_at(14'h0800, "comb_a");
      read_at(14'h1000, "comb_b");
      read_at(14'h0800, "comb_c");
      @(negedge clk);
      address = 14'h0800;
      in      = 16'hABCD;
      load    = 1'b1;
      check("rdw_before");
      @(posedge clk);
      ref_mem[14'h0800] = 16'hABCD;
      #1;
      load = 1'b0;
      check("rdw_after");

      // random traffic: half the operations reuse an address that was written before
      for (int i = 0; i < 300; i++) begin
         if (written_q.size() > 0 && $urandom_range(0, 1) == 1)
            a = written_q[$urandom_range(0, written_q.size() - 1)];
         else
            a = 14'($urandom_range(0, 16383));
         d = 16'($urandom);
         do_write(a, d, 1'($urandom_range(0, 1)), "rand_wr");
         @(negedge clk);
         read_at(14'($urandom_range(0, 16383)), "rand_rd");
         if (written_q.size() > 0)
            read_at(written_q[$urandom_range(0, written_q.size() - 1)], "rand_rd_hit");
      end

      // 6: asynchronous reset between clock edges
      @(negedge clk);
      address = 14'h1801;
      #2;
      rst_n = 1'b0;
      model_reset();
      check("async_rst_now");
      read_at(14'h2001, "async_rst_2001");
      do_write(14'h0800, 16'h5A5A, 1'b1, "wr_in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      read_at(14'h0800, "after_rst_wr");
      while (written_q.size() > 0) read_at(written_q.pop_front(), "after_rst_clear");
      do_write(14'h3FFF, 16'hBEEF, 1'b1, "post_rst_wr");

      // drain with a bounded wait
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) #1;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog timeout compared=%0d", compared);
      $fatal(1, "timeout");
   end

endmodule
